// File: rtl/sdram_req_arb.sv
// Two-port request arbiter in front of an SDRAM controller: one access at a time,
// strobe/ack handshake toward the controller. Define SDRAM_ARB_RR_EN for round-robin ties.
module sdram_req_arb (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [23:0] p0_addr,
  input  logic [15:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_done,
  output logic [15:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [23:0] p1_addr,
  input  logic [15:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_done,
  output logic [15:0] p1_rdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        mem_ack,
  output logic [23:0] mem_ab,
  output logic [15:0] mem_di,
  input  logic        mem_rdy,
  input  logic [15:0] mem_do
);

  typedef enum logic [2:0] {
    S_FLUSH = 3'd0,
    S_IDLE  = 3'd1,
    S_ISSUE = 3'd2,
    S_BUSY  = 3'd3,
    S_ACK   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        cnt_q, cnt_d;
  logic        we_q, we_d;
  logic        port_q, port_d;
  logic        p0_gnt_q, p0_gnt_d;
  logic        p1_gnt_q, p1_gnt_d;
  logic        p0_done_q, p0_done_d;
  logic        p1_done_q, p1_done_d;
  logic [15:0] p0_rdata_q, p0_rdata_d;
  logic [15:0] p1_rdata_q, p1_rdata_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic        mem_ack_q, mem_ack_d;
  logic [23:0] mem_ab_q, mem_ab_d;
  logic [15:0] mem_di_q, mem_di_d;
  logic        win;
`ifdef SDRAM_ARB_RR_EN
  // Port that wins the next tie; flips to the loser after every grant.
  logic        prio_q, prio_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    port_d     = port_q;
    p0_gnt_d   = 1'b0;
    p1_gnt_d   = 1'b0;
    p0_done_d  = 1'b0;
    p1_done_d  = 1'b0;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
    mem_rd_d   = mem_rd_q;
    mem_wr_d   = mem_wr_q;
    mem_ack_d  = mem_ack_q;
    mem_ab_d   = mem_ab_q;
    mem_di_d   = mem_di_q;
    win        = 1'b0;
`ifdef SDRAM_ARB_RR_EN
    prio_d     = prio_q;
`endif

    if (p0_req && p1_req) begin
`ifdef SDRAM_ARB_RR_EN
      win = prio_q;
`else
      win = 1'b0;
`endif
    end else begin
      win = p1_req;
    end

    case (state_q)
      S_FLUSH: begin
        mem_ack_d = 1'b1;
        if (cnt_q) begin
          cnt_d     = 1'b0;
          mem_ack_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = 1'b1;
        end
      end
      S_IDLE: begin
        if (mem_rdy && (p0_req || p1_req)) begin
          port_d   = win;
          p0_gnt_d = !win;
          p1_gnt_d = win;
          we_d     = win ? p1_we : p0_we;
          mem_ab_d = win ? p1_addr : p0_addr;
          mem_di_d = win ? p1_wdata : p0_wdata;
          mem_rd_d = !we_d;
          mem_wr_d = we_d;
`ifdef SDRAM_ARB_RR_EN
          prio_d   = !win;
`endif
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Controller drops mem_rdy once it has taken the strobe.
        if (!mem_rdy) state_d = S_BUSY;
      end
      S_BUSY: begin
        if (mem_rdy) begin
          mem_rd_d  = 1'b0;
          mem_wr_d  = 1'b0;
          mem_ack_d = 1'b1;
          cnt_d     = 1'b0;
          p0_done_d = !port_q;
          p1_done_d = port_q;
          if (!we_q) begin
            if (port_q) p1_rdata_d = mem_do;
            else        p0_rdata_d = mem_do;
          end
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (cnt_q) begin
          cnt_d     = 1'b0;
          mem_ack_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = 1'b1;
        end
      end
      default: begin
        state_d = S_FLUSH;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= S_FLUSH;
      cnt_q      <= 1'b0;
      we_q       <= 1'b0;
      port_q     <= 1'b0;
      p0_gnt_q   <= 1'b0;
      p1_gnt_q   <= 1'b0;
      p0_done_q  <= 1'b0;
      p1_done_q  <= 1'b0;
      p0_rdata_q <= 16'h0000;
      p1_rdata_q <= 16'h0000;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_ack_q  <= 1'b1;
      mem_ab_q   <= 24'h000000;
      mem_di_q   <= 16'h0000;
`ifdef SDRAM_ARB_RR_EN
      prio_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      port_q     <= port_d;
      p0_gnt_q   <= p0_gnt_d;
      p1_gnt_q   <= p1_gnt_d;
      p0_done_q  <= p0_done_d;
      p1_done_q  <= p1_done_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
      mem_ack_q  <= mem_ack_d;
      mem_ab_q   <= mem_ab_d;
      mem_di_q   <= mem_di_d;
`ifdef SDRAM_ARB_RR_EN
      prio_q     <= prio_d;
`endif
    end
  end

  assign p0_gnt   = p0_gnt_q;
  assign p1_gnt   = p1_gnt_q;
  assign p0_done  = p0_done_q;
  assign p1_done  = p1_done_q;
  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;
  assign mem_rd   = mem_rd_q;
  assign mem_wr   = mem_wr_q;
  assign mem_ack  = mem_ack_q;
  assign mem_ab   = mem_ab_q;
  assign mem_di   = mem_di_q;

endmodule

// File: tb/tb_sdram_req_arb.sv
// Directed bench for sdram_req_arb: reset/flush, read, write, contention,
// refresh blocking and reset during an access.
module tb_sdram_req_arb;

  logic        clk;
  logic        sys_rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [23:0] p0_addr, p1_addr;
  logic [15:0] p0_wdata, p1_wdata;
  logic        p0_gnt, p0_done, p1_gnt, p1_done;
  logic [15:0] p0_rdata, p1_rdata;
  logic        mem_rd, mem_wr, mem_ack, mem_rdy;
  logic [23:0] mem_ab;
  logic [15:0] mem_di, mem_do;

  int checks;
  int failures;
  int gnt_seen;
  logic exp1;

  sdram_req_arb dut (
    .sys_clk  (clk),
    .sys_rst  (sys_rst),
    .p0_req   (p0_req),
    .p0_we    (p0_we),
    .p0_addr  (p0_addr),
    .p0_wdata (p0_wdata),
    .p0_gnt   (p0_gnt),
    .p0_done  (p0_done),
    .p0_rdata (p0_rdata),
    .p1_req   (p1_req),
    .p1_we    (p1_we),
    .p1_addr  (p1_addr),
    .p1_wdata (p1_wdata),
    .p1_gnt   (p1_gnt),
    .p1_done  (p1_done),
    .p1_rdata (p1_rdata),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_ack  (mem_ack),
    .mem_ab   (mem_ab),
    .mem_di   (mem_di),
    .mem_rdy  (mem_rdy),
    .mem_do   (mem_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    gnt_seen = 0;
    sys_rst  = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = 24'h0; p0_wdata = 16'h0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = 24'h0; p1_wdata = 16'h0;
    mem_rdy = 1'b1; mem_do = 16'h0;
    repeat (3) step();

    // Reset state
    chk("rst_gnt",  32'({p0_gnt, p1_gnt}), 32'd0);
    chk("rst_done", 32'({p0_done, p1_done}), 32'd0);
    chk("rst_strb", 32'({mem_rd, mem_wr}), 32'd0);
    chk("rst_ack",  32'(mem_ack), 32'd1);
    chk("rst_rd0",  32'(p0_rdata), 32'd0);
    chk("rst_rd1",  32'(p1_rdata), 32'd0);
    chk("rst_ab",   32'(mem_ab), 32'd0);
    chk("rst_di",   32'(mem_di), 32'd0);

    // Flush after release: ack for 2 cycles, no strobes
    sys_rst = 1'b0;
    step();
    chk("flush_ack1",  32'(mem_ack), 32'd1);
    chk("flush_strb1", 32'({mem_rd, mem_wr}), 32'd0);
    step();
    chk("flush_ack2",  32'(mem_ack), 32'd0);
    chk("flush_strb2", 32'({mem_rd, mem_wr}), 32'd0);

    // Port 0 read at 012345 returning BEEF
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 24'h012345;
    step();
    chk("rd_gnt0", 32'(p0_gnt), 32'd1);
    chk("rd_gnt1", 32'(p1_gnt), 32'd0);
    chk("rd_strb", 32'({mem_rd, mem_wr}), 32'd2);
    chk("rd_ab",   32'(mem_ab), 32'h012345);
    chk("rd_ack",  32'(mem_ack), 32'd0);
    p0_req = 1'b0;
    step();
    chk("rd_gnt_pulse", 32'(p0_gnt), 32'd0);
    chk("rd_issue_hold", 32'(mem_rd), 32'd1);
    mem_rdy = 1'b0;
    step();
    chk("rd_busy_rd", 32'(mem_rd), 32'd1);
    chk("rd_busy_done", 32'(p0_done), 32'd0);
    step();
    chk("rd_busy_ab", 32'(mem_ab), 32'h012345);
    mem_rdy = 1'b1; mem_do = 16'hBEEF;
    step();
    mem_do = 16'h0000;
    chk("rd_done0",  32'(p0_done), 32'd1);
    chk("rd_done1",  32'(p1_done), 32'd0);
    chk("rd_rdata",  32'(p0_rdata), 32'hBEEF);
    chk("rd_strb_off", 32'({mem_rd, mem_wr}), 32'd0);
    chk("rd_ack1",   32'(mem_ack), 32'd1);
    step();
    chk("rd_ack2",   32'(mem_ack), 32'd1);
    chk("rd_done_pulse", 32'(p0_done), 32'd0);
    chk("rd_ack_ab", 32'(mem_ab), 32'h012345);
    step();
    chk("rd_ack_end", 32'(mem_ack), 32'd0);
    chk("rd_rdata_hold", 32'(p0_rdata), 32'hBEEF);

    // Port 1 write of 55AA at 000200
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 24'h000200; p1_wdata = 16'h55AA;
    step();
    chk("wr_gnt1", 32'(p1_gnt), 32'd1);
    chk("wr_gnt0", 32'(p0_gnt), 32'd0);
    chk("wr_strb", 32'({mem_rd, mem_wr}), 32'd1);
    chk("wr_ab",   32'(mem_ab), 32'h000200);
    chk("wr_di",   32'(mem_di), 32'h55AA);
    p1_req = 1'b0; mem_rdy = 1'b0;
    step();
    chk("wr_busy", 32'(mem_wr), 32'd1);
    mem_rdy = 1'b1; mem_do = 16'h1234;
    step();
    mem_do = 16'h0000;
    chk("wr_done1", 32'(p1_done), 32'd1);
    chk("wr_done0", 32'(p0_done), 32'd0);
    chk("wr_rdata1_keep", 32'(p1_rdata), 32'd0);
    chk("wr_rdata0_keep", 32'(p0_rdata), 32'hBEEF);
    chk("wr_ack", 32'(mem_ack), 32'd1);
    step();
    step();
    chk("wr_ack_end", 32'(mem_ack), 32'd0);

    // Both ports requesting continuously; grants every 5 cycles
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 24'h000010;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 24'h000020;
    for (int k = 0; k < 4; k++) begin
`ifdef SDRAM_ARB_RR_EN
      exp1 = k[0];
`else
      exp1 = 1'b0;
`endif
      step();
      chk("arb_gnt0", 32'(p0_gnt), 32'(!exp1));
      chk("arb_gnt1", 32'(p1_gnt), 32'(exp1));
      mem_rdy = 1'b0;
      step();
      chk("arb_nogap1", 32'({p0_gnt, p1_gnt}), 32'd0);
      mem_rdy = 1'b1;
      step();
      chk("arb_done0", 32'(p0_done), 32'(!exp1));
      chk("arb_done1", 32'(p1_done), 32'(exp1));
      step();
      chk("arb_nogap2", 32'({p0_gnt, p1_gnt}), 32'd0);
      step();
      chk("arb_nogap3", 32'({p0_gnt, p1_gnt}), 32'd0);
    end
    p0_req = 1'b0; p1_req = 1'b0;
    step();
    chk("arb_idle", 32'({p0_gnt, p1_gnt}), 32'd0);

    // mem_rdy low blocks grants
    mem_rdy = 1'b0;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 24'h0ABCDE;
    gnt_seen = 0;
    repeat (100) begin
      step();
      if (p0_gnt || p1_gnt) gnt_seen++;
    end
    chk("blk_nognt", 32'(gnt_seen), 32'd0);
    chk("blk_nostrb", 32'({mem_rd, mem_wr}), 32'd0);
    mem_rdy = 1'b1;
    step();
    chk("blk_gnt", 32'(p0_gnt), 32'd1);
    chk("blk_ab",  32'(mem_ab), 32'h0ABCDE);
    p0_req = 1'b0; mem_rdy = 1'b0;
    step();
    chk("blk_busy", 32'(mem_rd), 32'd1);

    // Reset in BUSY abandons the access
    sys_rst = 1'b1;
    step();
    chk("mid_strb", 32'({mem_rd, mem_wr}), 32'd0);
    chk("mid_done", 32'({p0_done, p1_done}), 32'd0);
    chk("mid_ack",  32'(mem_ack), 32'd1);
    sys_rst = 1'b0; mem_rdy = 1'b1; mem_do = 16'h7777;
    step();
    chk("mid_flush_ack", 32'(mem_ack), 32'd1);
    chk("mid_flush_done", 32'({p0_done, p1_done}), 32'd0);
    step();
    chk("mid_flush_end", 32'(mem_ack), 32'd0);
    chk("mid_rdata0", 32'(p0_rdata), 32'd0);
    mem_do = 16'h0000;

    // Next request after the abandoned one is served normally
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 24'h000321;
    step();
    chk("post_gnt1", 32'(p1_gnt), 32'd1);
    chk("post_strb", 32'({mem_rd, mem_wr}), 32'd2);
    chk("post_ab",   32'(mem_ab), 32'h000321);
    p1_req = 1'b0; mem_rdy = 1'b0;
    step();
    mem_rdy = 1'b1; mem_do = 16'hCAFE;
    step();
    mem_do = 16'h0000;
    chk("post_done1", 32'(p1_done), 32'd1);
    chk("post_rdata1", 32'(p1_rdata), 32'hCAFE);
    step();
    step();
    chk("post_ack_end", 32'(mem_ack), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_req_arb.md
SDRAM_REQ_ARB -- requirements
Module: sdram_req_arb

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: sys_clk and sys_rst.
REQ-002 The block SHALL have no parameters, and all widths SHALL be fixed as listed below.
REQ-003 sys_clk  in  1  system clock; all logic SHALL be rising-edge.
REQ-004 sys_rst  in  1  synchronous active-high reset.
REQ-005 pN_req  in  1  port N request, where N is 0 or 1; held high until pN_gnt.
REQ-006 pN_we  in  1  1 = write, 0 = read; valid while pN_req is high.
REQ-007 pN_addr  in  24  word address; pN_wdata  in  16  write data.
REQ-008 pN_gnt  out  1  one-cycle pulse when the request is accepted.
REQ-009 pN_done  out  1  one-cycle pulse when the access completes.
REQ-010 pN_rdata  out  16  read data, valid in the pN_done cycle of a read.
REQ-011 mem_rd, mem_wr  out  1 each  controller read and write strobes.
REQ-012 mem_ack  out  1  cycle-end acknowledge to the controller.
REQ-013 mem_ab  out  24; mem_di  out  16  address and write data to the controller.
REQ-014 mem_rdy  in  1  controller ready; mem_do  in  16  controller read data.

Function
REQ-015 The FSM SHALL have states FLUSH, IDLE, ISSUE, BUSY and ACK.
REQ-016 IDLE SHALL arbitrate only when mem_rdy=1 and at least one pN_req=1.
  - On a win: pulse the winner's pN_gnt for 1 cycle; latch we/addr/wdata and the port id; go to ISSUE.
REQ-017 ISSUE SHALL drive mem_rd=!we or mem_wr=we, with mem_ab/mem_di taken from the latch.
  - Stay in ISSUE until mem_rdy=0, then go to BUSY.
REQ-018 BUSY SHALL hold the strobe until mem_rdy=1.
  - In that cycle: capture mem_do into the granted port's pN_rdata (reads only); pulse pN_done; go to ACK.
REQ-019 ACK SHALL drive mem_rd=mem_wr=0 and mem_ack=1 for exactly 2 cycles, then go to IDLE.
REQ-020 mem_ab and mem_di SHALL stay stable from ISSUE entry through the end of ACK.
REQ-021 mem_rd and mem_wr SHALL never be high together, and neither SHALL be high while mem_ack=1.
REQ-022 At most one request SHALL be outstanding; pN_gnt SHALL never pulse outside IDLE.
REQ-023 Minimum spacing between two grants SHALL be 5 cycles.
REQ-024 Simultaneous pN_req, round-robin mode: grant the port not granted last; after reset, port 0 wins the first tie.
REQ-025 Simultaneous pN_req, fixed mode: port 0 SHALL always win.
REQ-026 A request arriving while the FSM is not in IDLE SHALL wait, with no loss and no gnt, until the FSM returns to IDLE.
REQ-027 pN_rdata SHALL hold its value until the next read completes on that port; writes SHALL leave pN_rdata unchanged.
REQ-028 mem_rdy=0 in IDLE (e.g. during controller refresh) SHALL block all grants.

Reset
REQ-029 While sys_rst=1, the outputs SHALL be:
  - pN_gnt, pN_done, mem_rd, mem_wr = 0.
  - mem_ack = 1.
  - pN_rdata, mem_ab, mem_di = 0.
  - Round-robin pointer = port 0.
REQ-030 On release, the FSM SHALL enter FLUSH.
  - FLUSH holds mem_ack=1 for 2 cycles, then goes to IDLE.
  - This terminates any controller cycle left in its ack-wait by a reset during BUSY or ACK.
REQ-031 Reset asserted mid-access SHALL abandon the access without a pN_done pulse.

Configuration
REQ-032 With SDRAM_ARB_RR_EN defined, arbitration SHALL be round-robin per REQ-024.
REQ-033 Without SDRAM_ARB_RR_EN, arbitration SHALL be fixed priority per REQ-025; the pointer register SHALL be absent.

Verification
REQ-034 Reset release with mem_rdy=1 -> mem_ack=1 for 2 cycles, then 0; no strobe during that period.
REQ-035 Port 0 read at addr 24'h012345, with mem_do=16'hBEEF when mem_rdy rises:
  - p0_gnt pulses; mem_rd=1 with mem_ab=24'h012345 until mem_rdy returns to 1.
  - p0_done pulses with p0_rdata=16'hBEEF; mem_ack=1 for 2 cycles.
REQ-036 Port 1 write of 16'h55AA at addr 24'h000200 -> mem_wr=1, mem_di=16'h55AA, p1_done pulses, p1_rdata unchanged.
REQ-037 Both ports requesting continuously, RR build -> grants alternate 0,1,0,1; fixed build -> all grants go to 0.
REQ-038 mem_rdy held 0 for 100 cycles with p0_req=1 -> no gnt; gnt pulses 1 cycle after mem_rdy returns to 1.
REQ-039 sys_rst pulsed during BUSY -> strobes drop, no done pulse, FLUSH ack issued, next request served normally.
